// File: rtl/params_pkg.sv
// params_pkg: shared widths and the aggregator FSM state type.
package params_pkg;
  localparam int NUM_OF_NODES     = 168;
  localparam int NUM_NODE_WIDTH   = 8;
  localparam int NUM_FEATURES     = 16;
  localparam int DATA_WIDTH       = 16;
  localparam int ALPHA_DATA_WIDTH = 16;
  localparam int ALPHA_FRAC       = 15;
  localparam int ACC_WIDTH        = DATA_WIDTH + ALPHA_DATA_WIDTH + 1 + NUM_NODE_WIDTH;
  localparam int OUT_WIDTH        = 16;
  typedef enum logic [1:0] {IDLE, ACCUM, ROUND, OUT} agg_state_t;
endpackage

// File: rtl/agg_round_sat.sv
// agg_round_sat: rounds one accumulator lane to nearest (half up), drops the alpha fraction, saturates.
module agg_round_sat #(
  parameter int ACC_WIDTH  = 41,
  parameter int OUT_WIDTH  = 16,
  parameter int ALPHA_FRAC = 15
) (
  input  logic signed [ACC_WIDTH-1:0] acc_i,
  output logic signed [OUT_WIDTH-1:0] out_o
);
  localparam logic signed [ACC_WIDTH:0] RND   = (ACC_WIDTH+1)'(2**(ALPHA_FRAC-1));
  localparam logic signed [ACC_WIDTH:0] W_MAX = {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] W_MIN = {{(ACC_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  logic signed [ACC_WIDTH:0] w_sum, w_shift;
  // one extra bit so the rounding add cannot wrap
  assign w_sum   = $signed({acc_i[ACC_WIDTH-1], acc_i}) + RND;
  assign w_shift = w_sum >>> ALPHA_FRAC;
  always_comb
    out_o = w_shift > W_MAX ? W_MAX[OUT_WIDTH-1:0] :
            w_shift < W_MIN ? W_MIN[OUT_WIDTH-1:0] : w_shift[OUT_WIDTH-1:0];
endmodule

// File: rtl/aggregator.sv
// aggregator: alpha-weighted sum of neighbour feature rows, rounded and saturated per lane.
module aggregator
  import params_pkg::*;
(
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     alpha_valid_i,
  input  logic [NUM_OF_NODES*ALPHA_DATA_WIDTH-1:0] alpha_i,
  input  logic [NUM_NODE_WIDTH-1:0]                num_of_nodes_i,
  output logic                                     alpha_ready_o,
  input  logic                                     feat_valid_i,
  input  logic [NUM_FEATURES*DATA_WIDTH-1:0]       feat_i,
  output logic                                     feat_ready_o,
  output logic                                     out_valid_o,
  input  logic                                     out_ready_i,
  output logic [NUM_FEATURES*OUT_WIDTH-1:0]        out_data_o,
  output logic                                     overrun_o
);
  localparam int PW = DATA_WIDTH + ALPHA_DATA_WIDTH + 1;
  localparam logic [NUM_NODE_WIDTH-1:0] N_MAX = NUM_NODE_WIDTH'(NUM_OF_NODES);
  agg_state_t r_state;
  logic [NUM_OF_NODES*ALPHA_DATA_WIDTH-1:0] r_alpha;
  logic [NUM_NODE_WIDTH-1:0] r_n, r_j, w_n;
  logic signed [ACC_WIDTH-1:0] r_acc [NUM_FEATURES];
  logic signed [PW-1:0] w_prod [NUM_FEATURES];
  logic [NUM_FEATURES*OUT_WIDTH-1:0] w_out;
  logic [ALPHA_DATA_WIDTH-1:0] w_alpha;
  assign w_n           = num_of_nodes_i > N_MAX ? N_MAX : num_of_nodes_i;
  assign w_alpha       = r_alpha[r_j*ALPHA_DATA_WIDTH +: ALPHA_DATA_WIDTH];
  assign alpha_ready_o = r_state == IDLE;
  assign feat_ready_o  = r_state == ACCUM;
  assign out_valid_o   = r_state == OUT;
  genvar g;
  generate
    for (g = 0; g < NUM_FEATURES; g++) begin : g_lane
      // alpha is unsigned Q1.15, so it enters the signed multiply zero-extended
      assign w_prod[g] = PW'($signed(feat_i[g*DATA_WIDTH +: DATA_WIDTH])) * PW'($signed({1'b0, w_alpha}));
      agg_round_sat #(.ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH), .ALPHA_FRAC(ALPHA_FRAC)) u_rs (
        .acc_i(r_acc[g]),
        .out_o(w_out[g*OUT_WIDTH +: OUT_WIDTH])
      );
    end
  endgenerate
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= IDLE;
      r_alpha    <= '0;
      r_n        <= '0;
      r_j        <= '0;
      out_data_o <= '0;
      overrun_o  <= 1'b0;
      for (int f = 0; f < NUM_FEATURES; f++) r_acc[f] <= '0;
    end else begin
      if (alpha_valid_i && r_state != IDLE) overrun_o <= 1'b1;
      case (r_state)
        IDLE: if (alpha_valid_i) begin
          r_alpha <= alpha_i;
          r_n     <= w_n;
          r_j     <= '0;
          for (int f = 0; f < NUM_FEATURES; f++) r_acc[f] <= '0;
          r_state <= w_n == '0 ? ROUND : ACCUM;
        end
        ACCUM: if (feat_valid_i) begin
          for (int f = 0; f < NUM_FEATURES; f++) r_acc[f] <= r_acc[f] + ACC_WIDTH'(w_prod[f]);
          r_j <= r_j + 1'b1;
          if (r_j == r_n - 1'b1) r_state <= ROUND;
        end
        ROUND: begin
          out_data_o <= w_out;
          r_state    <= OUT;
        end
        default: if (out_ready_i) r_state <= IDLE;
      endcase
    end
endmodule
